// File: rtl/rst_chk_pkg.sv
// rst_chk_pkg: shared FSM state type and event-counter constants for rst_chk
package rst_chk_pkg;
    typedef enum logic [1:0] {WAIT_RST, ASSERTED, RELEASED} state_e;
    localparam int EVT_CNT_W = 8;
    localparam logic [EVT_CNT_W-1:0] EVT_CNT_MAX = 8'd255;
endpackage

// File: rtl/rst_chk_sync.sv
// rst_chk_sync: two-flop synchronizer that resets to 1 (reset deasserted)
module rst_chk_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], d_i};
    end
    assign q_o = sync_q[1];
endmodule

// File: rtl/rst_chk.sv
// rst_chk: measures observed active-low reset pulses and flags short/long ones; RST_CHK_SYNC_EN adds an input synchronizer
module rst_chk
    import rst_chk_pkg::*;
#(
    parameter int MIN_RST_CYCLES = 16,
    parameter int MAX_RST_CYCLES = 64,
    parameter int CNT_W = $clog2((MIN_RST_CYCLES > MAX_RST_CYCLES ? MIN_RST_CYCLES : MAX_RST_CYCLES) + 2)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 mon_rst_ni,
    input  logic                 clr_i,
    output logic                 rst_active_o,
    output logic                 ready_o,
    output logic                 rst_done_o,
    output logic [CNT_W-1:0]     rst_len_o,
    output logic [EVT_CNT_W-1:0] rst_evt_o,
    output logic                 err_short_o,
    output logic                 err_long_o
);
    logic s;
`ifdef RST_CHK_SYNC_EN
    rst_chk_sync u_sync (.clk_i(clk_i), .rst_i(rst_i), .d_i(mon_rst_ni), .q_o(s));
`else
    assign s = mon_rst_ni;
`endif

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     len_q, len_d, rlen_q, rlen_d;
    logic [EVT_CNT_W-1:0] evt_q, evt_d, evt_inc;
    logic                 active_q, active_d, ready_q, ready_d, done_q, done_d;
    logic                 es_q, es_d, el_q, el_d;

    assign evt_inc = (evt_q == EVT_CNT_MAX) ? evt_q : evt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        rlen_d  = rlen_q;
        evt_d   = evt_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        es_d    = es_q & ~clr_i;
        el_d    = el_q & ~clr_i;
        unique case (state_q)
            WAIT_RST, RELEASED: begin
                if (!s) begin
                    state_d = ASSERTED;
                    len_d   = CNT_W'(1);
                    evt_d   = evt_inc;
                    ready_d = 1'b0;
                end
            end
            ASSERTED: begin
                if (!s) begin
                    len_d = (len_q == '1) ? len_q : len_q + 1'b1;
                    if (MAX_RST_CYCLES != 0 && len_d == CNT_W'(MAX_RST_CYCLES + 1) && len_q != len_d) el_d = 1'b1;
                end else begin
                    rlen_d = len_q;
                    if (len_q < CNT_W'(MIN_RST_CYCLES)) begin
                        es_d    = 1'b1;
                        state_d = WAIT_RST;
                    end else begin
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        state_d = RELEASED;
                    end
                end
            end
            default: state_d = WAIT_RST;
        endcase
        active_d = (state_d == ASSERTED);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= WAIT_RST;
            len_q    <= '0;
            rlen_q   <= '0;
            evt_q    <= '0;
            active_q <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            es_q     <= 1'b0;
            el_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            rlen_q   <= rlen_d;
            evt_q    <= evt_d;
            active_q <= active_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            es_q     <= es_d;
            el_q     <= el_d;
        end
    end

    assign rst_active_o = active_q;
    assign ready_o      = ready_q;
    assign rst_done_o   = done_q;
    assign rst_len_o    = rlen_q;
    assign rst_evt_o    = evt_q;
    assign err_short_o  = es_q;
    assign err_long_o   = el_q;
endmodule

// File: tb/tb_rst_chk.sv
// tb_rst_chk: directed plus random pulse trains checked against a run-length reference model
module tb_rst_chk;
    localparam int MIN = 16;
    localparam int MAX = 64;
    localparam int CNT_W = $clog2(MAX + 2);
    localparam int CAP = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, mon_n, clr;
    logic active, ready, done, err_s, err_l;
    logic [CNT_W-1:0] rlen;
    logic [7:0] evt;

    int checks = 0;
    int errors = 0;
    int m_run, m_rlen, m_evt;
    bit m_prev_low, m_active, m_ready, m_done, m_es, m_el;

    always #5 clk = ~clk;

    rst_chk #(.MIN_RST_CYCLES(MIN), .MAX_RST_CYCLES(MAX)) dut (
        .clk_i(clk), .rst_i(rst), .mon_rst_ni(mon_n), .clr_i(clr),
        .rst_active_o(active), .ready_o(ready), .rst_done_o(done),
        .rst_len_o(rlen), .rst_evt_o(evt), .err_short_o(err_s), .err_long_o(err_l)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit s, input bit c, input bit r);
        if (r) begin
            {m_prev_low, m_active, m_ready, m_done, m_es, m_el} = '0;
            m_run = 0; m_rlen = 0; m_evt = 0;
            return;
        end
        m_done = 0;
        if (c) begin m_es = 0; m_el = 0; end
        m_active = !s;
        if (!s) begin
            if (!m_prev_low) begin
                m_evt = (m_evt < 255) ? m_evt + 1 : 255;
                m_run = 1;
                m_ready = 0;
            end else begin
                m_run = (m_run < CAP) ? m_run + 1 : CAP;
                if (MAX != 0 && m_run == MAX + 1) m_el = 1;
            end
        end else if (m_prev_low) begin
            m_rlen = m_run;
            if (m_run < MIN) m_es = 1;
            else begin m_done = 1; m_ready = 1; end
        end
        m_prev_low = !s;
    endtask

    task automatic step(input bit s, input bit c = 0, input bit r = 0);
        mon_n = s; clr = c; rst = r;
        @(posedge clk);
        model(s, c, r);
        #1;
        check("active", active, m_active);
        check("ready", ready, m_ready);
        check("done", done, m_done);
        check("len", rlen, m_rlen);
        check("evt", evt, m_evt);
        check("err_short", err_s, m_es);
        check("err_long", err_l, m_el);
    endtask

    task automatic low(input int n);
        for (int i = 0; i < n; i++) step(0);
    endtask

    initial begin
        rst = 1; mon_n = 1; clr = 0;
        step(1, 0, 1);
        step(1, 0, 1);
        for (int i = 0; i < 50; i++) step(1);
        check("pwrup_ready", ready, 0);
        check("pwrup_evt", evt, 0);
        low(16);
        step(1);
        check("legal_done", done, 1);
        check("legal_len", rlen, 16);
        check("legal_evt", evt, 1);
        step(1);
        check("done_once", done, 0);
        check("ready_held", ready, 1);
        step(0);
        check("second_active", active, 1);
        check("second_ready", ready, 0);
        check("second_evt", evt, 2);
        low(14);
        step(1);
        check("short_err", err_s, 1);
        check("short_len", rlen, 15);
        check("short_done", done, 0);
        low(64);
        check("long_not_yet", err_l, 0);
        step(0);
        check("long_err", err_l, 1);
        low(5);
        step(1);
        check("long_len", rlen, 70);
        check("long_ready", ready, 1);
        step(1, 1);
        check("clr_short", err_s, 0);
        check("clr_long", err_l, 0);
        low(3);
        step(1, 1);
        check("set_wins", err_s, 1);
        step(1, 1);
        check("clr_alone", err_s, 0);
        low(CAP + 10);
        step(1);
        check("sat_len", rlen, CAP);
        low(5);
        step(0, 0, 1);
        check("rst_active", active, 0);
        check("rst_evt", evt, 0);
        check("rst_err", err_l, 0);
        step(1);
        for (int i = 0; i < 260; i++) begin step(0); step(1); end
        check("evt_sat", evt, 255);
        for (int k = 0; k < 120; k++) begin
            int n = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 20) : $urandom_range(60, 70);
            for (int i = 0; i < n; i++) step(0, $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) step(1, $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
